// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter sequencing controller.
package cnt_seq_pkg;

  localparam int CNT_SEQ_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    DONE
  } cnt_seq_state_e;

endpackage

// File: rtl/cnt_seq_shadow.sv
// Shadow of the external counter: expected value, remaining step count, and
// the comparison against the value read back from the counter.
module cnt_seq_shadow
  import cnt_seq_pkg::*;
#(
  parameter int W = CNT_SEQ_W
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic         step,
  input  logic         up,
  input  logic [W-1:0] start_val,
  input  logic [W-1:0] end_val,
  input  logic [W-1:0] cnt_q,
  output logic [W-1:0] steps,
  output logic         mismatch
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] exp_val;

  // Distance is plain unsigned |end-start|; the direction never takes a modular shortcut.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      exp_val <= '0;
      steps   <= '0;
    end else if (load) begin
      exp_val <= start_val;
      steps   <= (end_val >= start_val) ? (end_val - start_val) : (start_val - end_val);
    end else if (step) begin
      exp_val <= up ? (exp_val + ONE) : (exp_val - ONE);
      steps   <= steps - ONE;
    end
  end

  assign mismatch = (cnt_q != exp_val);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequences an external up/down counter from start to end, checking every step
// against a shadow copy. Handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high only while idle and commands are never queued.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int W            = CNT_SEQ_W,
  parameter int MAX_ERR_HOLD = 1
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [W-1:0]   cmd_start,
  input  logic [W-1:0]   cmd_end,
  input  logic           cmd_abort,
  input  logic [W-1:0]   cnt_q,
  output logic           ld_cnt_,
  output logic [W-1:0]   cnt_d,
  output logic           updn_cnt,
  output logic           count_enb,
  output logic           busy,
  output logic           done,
  output logic           err,
  output cnt_seq_state_e dbg_state
);

  localparam logic [W-1:0] ONE = 1;

  cnt_seq_state_e state, state_n;
  logic           ld_n, enb_n, updn_n, done_n, err_n, sh_load;
  logic [W-1:0]   cnt_d_n;
  logic [W-1:0]   steps;
  logic           mismatch;

  cnt_seq_shadow #(.W(W)) u_shadow (
    .clk       (clk),
    .rst_      (rst_),
    .load      (sh_load),
    .step      (count_enb),
    .up        (updn_cnt),
    .start_val (cmd_start),
    .end_val   (cmd_end),
    .cnt_q     (cnt_q),
    .steps     (steps),
    .mismatch  (mismatch)
  );

  // Outputs are registered from the next state, so each takes effect in the
  // cycle the FSM spends in that state.
  always_comb begin
    state_n = state;
    ld_n    = 1'b1;
    enb_n   = 1'b0;
    updn_n  = updn_cnt;
    cnt_d_n = cnt_d;
    err_n   = (MAX_ERR_HOLD != 0) ? err : 1'b0;
    sh_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = LOAD;
          ld_n    = 1'b0;
          cnt_d_n = cmd_start;
          updn_n  = (cmd_end >= cmd_start);
          err_n   = 1'b0;
          sh_load = 1'b1;
        end
      end
      LOAD: begin
        state_n = cmd_abort ? DONE : CHECK;
      end
      CHECK: begin
        if (mismatch) err_n = 1'b1;
        if (cmd_abort || mismatch || (steps == '0)) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
          enb_n   = 1'b1;
        end
      end
      RUN: begin
        // steps==1 here means the edge ending this cycle makes the final move.
        if (mismatch) err_n = 1'b1;
        if (cmd_abort || mismatch || (steps == ONE)) begin
          state_n = DONE;
        end else begin
          enb_n = 1'b1;
        end
      end
      DONE: begin
        if (mismatch) err_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign done_n = (state_n == DONE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      ld_cnt_   <= 1'b1;
      cnt_d     <= '0;
      updn_cnt  <= 1'b1;
      count_enb <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      ld_cnt_   <= ld_n;
      cnt_d     <= cnt_d_n;
      updn_cnt  <= updn_n;
      count_enb <= enb_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: a behavioural up/down counter closes the loop and
// per-scenario tasks compare cycle-level observations against expected timing.
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_ = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [W-1:0]   cmd_start = '0;
  logic [W-1:0]   cmd_end = '0;
  logic           cmd_abort = 1'b0;
  logic [W-1:0]   cnt_q = '0;
  logic           ld_cnt_;
  logic [W-1:0]   cnt_d;
  logic           updn_cnt, count_enb, busy, done, err;
  cnt_seq_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int skip_step = -1;
  int en_idx = 0;

  typedef struct {
    int ld_n, ld_first, enb_n, enb_first, enb_last, done_n, done_cyc;
    bit overlap, err_seen, err_end, updn_first, updn_last, busy_end, ready_end, ready_mid;
    logic [W-1:0] cnt_done, cnt_end;
  } obs_t;

  cnt_seq_ctrl #(.W(W), .MAX_ERR_HOLD(1)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_abort (cmd_abort),
    .cnt_q     (cnt_q),
    .ld_cnt_   (ld_cnt_),
    .cnt_d     (cnt_d),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural counter; skip_step makes the Nth enabled edge after a load hold still.
  always @(posedge clk) begin
    if (!ld_cnt_) begin
      cnt_q  <= cnt_d;
      en_idx <= 0;
    end else if (count_enb) begin
      if (en_idx + 1 != skip_step) cnt_q <= updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
      en_idx <= en_idx + 1;
    end
  end

  // Driver: presents a command at once (caller sits mid-cycle), then samples
  // cycles 1..max_cyc at the falling edge.
  task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] e, input int max_cyc,
                         input int abort_cyc, input bit hold_valid, output obs_t o);
    o = '{default: 0};
    o.ld_first = -1;
    o.enb_first = -1;
    o.enb_last = -1;
    o.done_cyc = -1;
    cmd_start = s;
    cmd_end = e;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold_valid) begin
      cmd_start = ~s;
      cmd_end = s;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (!ld_cnt_) begin
        o.ld_n++;
        if (o.ld_first < 0) o.ld_first = c;
      end
      if (count_enb) begin
        o.enb_n++;
        if (o.enb_first < 0) o.enb_first = c;
        o.enb_last = c;
      end
      if (!ld_cnt_ && count_enb) o.overlap = 1'b1;
      if (done) begin
        o.done_n++;
        o.done_cyc = c;
        o.cnt_done = cnt_q;
        cmd_valid = 1'b0;
      end
      if (err) o.err_seen = 1'b1;
      if (c == 1) o.updn_first = updn_cnt;
      if (c == 2) o.ready_mid = cmd_ready;
      cmd_abort = (c == abort_cyc);
    end
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    o.updn_last = updn_cnt;
    o.err_end = err;
    o.busy_end = busy;
    o.ready_end = cmd_ready;
    o.cnt_end = cnt_q;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_cmp += 9;
    if (ld_cnt_ !== 1'b1)   begin n_bad++; $display("FAIL reset_ld got %b want 1", ld_cnt_); end
    if (count_enb !== 1'b0) begin n_bad++; $display("FAIL reset_enb got %b want 0", count_enb); end
    if (updn_cnt !== 1'b1)  begin n_bad++; $display("FAIL reset_updn got %b want 1", updn_cnt); end
    if (cnt_d !== '0)       begin n_bad++; $display("FAIL reset_cnt_d got %h want 0", cnt_d); end
    if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    rst_ = 1'b1;
  endtask

  // Normal completion: timing derived from N = |end-start| alone.
  task automatic test_count(input logic [W-1:0] s, input logic [W-1:0] e, input bit hold_valid);
    obs_t o;
    bit up;
    int n;
    up = (e >= s);
    n = up ? int'(e) - int'(s) : int'(s) - int'(e);
    run_cmd(s, e, 4 + n, 0, hold_valid, o);
    n_cmp += 13;
    if (o.ld_n !== 1 || o.ld_first !== 1)
      begin n_bad++; $display("FAIL count_ld %h->%h got %0d@%0d want 1@1", s, e, o.ld_n, o.ld_first); end
    if (o.enb_n !== n)
      begin n_bad++; $display("FAIL count_enb_n %h->%h got %0d want %0d", s, e, o.enb_n, n); end
    if (o.done_n !== 1)
      begin n_bad++; $display("FAIL count_done_n %h->%h got %0d want 1", s, e, o.done_n); end
    if (o.done_cyc !== 3 + n)
      begin n_bad++; $display("FAIL count_done_cyc %h->%h got %0d want %0d", s, e, o.done_cyc, 3 + n); end
    if (o.overlap !== 1'b0)
      begin n_bad++; $display("FAIL count_overlap %h->%h got 1 want 0", s, e); end
    if (o.err_seen !== 1'b0)
      begin n_bad++; $display("FAIL count_err %h->%h got 1 want 0", s, e); end
    if (o.cnt_done !== e)
      begin n_bad++; $display("FAIL count_final %h->%h got %h want %h", s, e, o.cnt_done, e); end
    if (o.updn_first !== up)
      begin n_bad++; $display("FAIL count_updn %h->%h got %b want %b", s, e, o.updn_first, up); end
    if (o.updn_last !== up)
      begin n_bad++; $display("FAIL count_updn_hold %h->%h got %b want %b", s, e, o.updn_last, up); end
    if (o.busy_end !== 1'b0)
      begin n_bad++; $display("FAIL count_busy_end %h->%h got 1 want 0", s, e); end
    if (o.ready_end !== 1'b1)
      begin n_bad++; $display("FAIL count_ready_end %h->%h got 0 want 1", s, e); end
    if (o.ready_mid !== 1'b0)
      begin n_bad++; $display("FAIL count_ready_mid %h->%h got 1 want 0", s, e); end
    if (o.cnt_end !== e)
      begin n_bad++; $display("FAIL count_hold %h->%h got %h want %h", s, e, o.cnt_end, e); end
    if (n > 0) begin
      n_cmp++;
      if (o.enb_first !== 3)
        begin n_bad++; $display("FAIL count_enb_first %h->%h got %0d want 3", s, e, o.enb_first); end
    end
  endtask

  // Counter misses its 2nd increment of 0->5; cnt_q first differs in cycle 5.
  task automatic test_error;
    obs_t o;
    int mm;
    mm = 3 + 2;
    skip_step = 2;
    run_cmd(16'd0, 16'd5, 12, 0, 1'b0, o);
    skip_step = -1;
    n_cmp += 6;
    if (o.err_seen !== 1'b1) begin n_bad++; $display("FAIL error_seen got 0 want 1"); end
    if (o.done_n !== 1)      begin n_bad++; $display("FAIL error_done_n got %0d want 1", o.done_n); end
    if (o.done_cyc <= mm || o.done_cyc > mm + 2)
      begin n_bad++; $display("FAIL error_done_cyc got %0d want %0d..%0d", o.done_cyc, mm + 1, mm + 2); end
    if (o.enb_last >= o.done_cyc)
      begin n_bad++; $display("FAIL error_enb_after got %0d want <%0d", o.enb_last, o.done_cyc); end
    if (o.err_end !== 1'b1)  begin n_bad++; $display("FAIL error_hold got 0 want 1"); end
    if (o.busy_end !== 1'b0) begin n_bad++; $display("FAIL error_busy_end got 1 want 0"); end
  endtask

  task automatic test_abort;
    obs_t o;
    run_cmd(16'd0, 16'd100, 8, 4, 1'b0, o);
    n_cmp += 6;
    if (o.done_cyc !== 5) begin n_bad++; $display("FAIL abort_done_cyc got %0d want 5", o.done_cyc); end
    if (o.done_n !== 1)   begin n_bad++; $display("FAIL abort_done_n got %0d want 1", o.done_n); end
    if (o.err_seen !== 1'b0) begin n_bad++; $display("FAIL abort_err got 1 want 0"); end
    if (o.cnt_done !== 16'd2 && o.cnt_done !== 16'd3)
      begin n_bad++; $display("FAIL abort_cnt got %h want 2 or 3", o.cnt_done); end
    if (o.cnt_end !== o.cnt_done)
      begin n_bad++; $display("FAIL abort_stable got %h want %h", o.cnt_end, o.cnt_done); end
    if (o.enb_last > 4) begin n_bad++; $display("FAIL abort_enb_last got %0d want <=4", o.enb_last); end
    // Abort while loading: counter still loads, no counting at all.
    run_cmd(16'd0, 16'd100, 6, 1, 1'b0, o);
    n_cmp += 3;
    if (o.done_cyc !== 2) begin n_bad++; $display("FAIL abort_ld_done got %0d want 2", o.done_cyc); end
    if (o.enb_n !== 0)    begin n_bad++; $display("FAIL abort_ld_enb got %0d want 0", o.enb_n); end
    if (o.cnt_end !== 16'd0) begin n_bad++; $display("FAIL abort_ld_cnt got %h want 0", o.cnt_end); end
  endtask

  task automatic test_reset_mid_run;
    int dn;
    dn = 0;
    cmd_start = 16'h0080;
    cmd_end = 16'h0020;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_ = 1'b0;
    #1;
    n_cmp += 8;
    if (ld_cnt_ !== 1'b1)   begin n_bad++; $display("FAIL rstmid_ld got %b want 1", ld_cnt_); end
    if (count_enb !== 1'b0) begin n_bad++; $display("FAIL rstmid_enb got %b want 0", count_enb); end
    if (updn_cnt !== 1'b1)  begin n_bad++; $display("FAIL rstmid_updn got %b want 1", updn_cnt); end
    if (cnt_d !== '0)       begin n_bad++; $display("FAIL rstmid_cnt_d got %h want 0", cnt_d); end
    if (err !== 1'b0)       begin n_bad++; $display("FAIL rstmid_err got %b want 0", err); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got %b want 1", cmd_ready); end
    if (done !== 1'b0)      begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_ = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", dn); end
    test_count(16'd7, 16'd9, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_count(16'h0100, 16'h0103, 1'b1);
    test_count(16'h0103, 16'h00FE, 1'b0);
    test_count(16'h0042, 16'h0042, 1'b1);
  endtask

  task automatic test_random;
    logic [W-1:0] s, e;
    int off;
    for (int i = 0; i < 8; i++) begin
      s = 16'($urandom_range(100, 60000));
      off = $urandom_range(0, 25);
      e = $urandom_range(0, 1) ? s + 16'(off) : s - 16'(off);
      test_count(s, e, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count(16'h0010, 16'h0014, 1'b0);
    test_count(16'h0005, 16'h0002, 1'b0);
    test_count(16'h1234, 16'h1234, 1'b0);
    test_error();
    test_count(16'h0003, 16'h0001, 1'b0);
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: data width of counter values.
REQ-002 SHALL have parameter MAX_ERR_HOLD, default 1: 1 = err stays set until the next accepted command; 0 = err is a one-cycle pulse.
REQ-003 SHALL have ports, with reset rst_ asynchronous, active-low, and clock clk:
- clk        in   1  clock, rising edge
- rst_       in   1  asynchronous active-low reset
- cmd_valid  in   1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_start  in   W  initial count value
- cmd_end    in   W  target count value
- cmd_abort  in   1  stop the current sequence
- cnt_q      in   W  counter output observed back
- ld_cnt_    out  1  counter load, active-low
- cnt_d      out  W  counter load data
- updn_cnt   out  1  1 = count up, 0 = count down
- count_enb  out  1  counter enable
- busy       out  1  a sequence is in progress
- done       out  1  one-cycle completion pulse
- err        out  1  cnt_q disagreed with the expected value

Function
REQ-004 SHALL drive an up/down counter with synchronous load and enable from start to end, and SHALL check every step against an internal shadow value.
REQ-005 SHALL implement states IDLE, LOAD, CHECK, RUN and DONE.
REQ-006 IDLE: cmd_ready=1 only in IDLE; on accept, SHALL capture start and end, set updn_cnt=(end>=start, unsigned), set steps=|end-start| (W-bit unsigned), then go to LOAD.
REQ-007 LOAD: lasts exactly one cycle; ld_cnt_=0, cnt_d=start, count_enb=0, exp=start; next state is CHECK.
REQ-008 CHECK: one cycle; if cnt_q!=exp, SHALL set err and go to DONE; else go to RUN if steps!=0, otherwise to DONE.
REQ-009 RUN: count_enb=1 for exactly steps consecutive cycles; at each enabled edge, exp moves by ±1 (modulo 2^W) and steps decrements; go to DONE on the edge where steps reaches 0.
REQ-010 In RUN and DONE, SHALL compare cnt_q with exp every cycle; on mismatch, SHALL set err, drop count_enb on the next cycle and go to DONE.
REQ-011 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-012 Latency with N=steps: accept at edge 0; ld_cnt_ low during cycle 1; done high during cycle 3+N (no RUN cycles when N=0).
REQ-013 SHALL never assert ld_cnt_=0 and count_enb=1 in the same cycle.
REQ-014 All outputs SHALL be registered, except cmd_ready and busy, which decode state (busy=state!=IDLE).
REQ-015 cmd_abort in LOAD, CHECK or RUN: count_enb=0 from the next cycle, go to DONE, done pulses, err unchanged; cmd_abort in IDLE or DONE is ignored.
REQ-016 cmd_abort has priority over a simultaneous mismatch; the mismatch error is still recorded.
REQ-017 Wrap-around: start=0xFFFF, end=0x0002 counts down 0xFFFD steps; no modular-shortest path is taken.
REQ-018 cmd_valid outside IDLE SHALL be ignored; the command is not queued.
REQ-019 updn_cnt and cnt_d SHALL hold their values outside LOAD and RUN.

Reset
REQ-020 Asserting rst_ low SHALL immediately force: state=IDLE, ld_cnt_=1, count_enb=0, updn_cnt=1, cnt_d=0, done=0, err=0, busy=0, cmd_ready=1.
REQ-021 Reset mid-sequence SHALL abandon the sequence with no done pulse.
REQ-022 A command presented in the first cycle after rst_ deasserts SHALL be accepted.

Structure
REQ-023 Package cnt_seq_pkg SHALL hold the state enum type and the default width constant.
REQ-024 Sub-module cnt_seq_shadow SHALL hold exp and the steps down-counter, with load, step and direction inputs, plus the mismatch compare.

Verification
REQ-025 Bench SHALL pair the DUT with a behavioural up/down counter model and cover:
- start=0x0010, end=0x0014 -> ld_cnt_ low 1 cycle; count_enb high 4 cycles, updn=1; done in cycle 7; err=0; cnt_q=0x0014.
- start=0x0005, end=0x0002 -> updn=0, 3 enabled cycles, done in cycle 6, cnt_q=0x0002.
- start=end=0x1234 -> no count_enb, done in cycle 3.
- Model forced to skip one increment at step 2 of 0->5 -> err=1 and done within 2 cycles of the mismatch; count_enb low afterwards.
- cmd_abort in cycle 2 of RUN, 0->100 -> done next+1 cycle; cnt_q=2 or 3, then stable; err=0.
- rst_ low during RUN, then a new command 7->9 -> all outputs at reset values, no done pulse; the new command completes correctly.
